// File: rtl/mc_controller_if.sv
// Bundle of IR fields, memory/MDU handshakes and decoded controls between the
// multi-cycle MIPS controller (master) and the datapath (slave).
interface mc_controller_if #(
    parameter int ALUOP_W = 7,
    parameter int WTR_W   = 8
);
    logic [5:0]         op;
    logic [5:0]         func;
    logic               im_ready;
    logic               dm_ready;
    logic               md_busy;
    logic               ir_we;
    logic               pc_we;
    logic [ALUOP_W-1:0] ALUop;
    logic               Wegrf;
    logic               WeDm;
    logic [3:0]         branch;
    logic [3:0]         AluSrc1;
    logic [3:0]         AluSrc2;
    logic [WTR_W-1:0]   WhichtoReg;
    logic [3:0]         RegDst;
    logic               SignExt;
    logic [3:0]         B_change;
    logic [3:0]         DM_type;
    logic               md_start;
    logic [1:0]         md_op;
    logic               ri;
    logic [2:0]         state;

    modport master (
        input  op, func, im_ready, dm_ready, md_busy,
        output ir_we, pc_we, ALUop, Wegrf, WeDm, branch, AluSrc1, AluSrc2,
               WhichtoReg, RegDst, SignExt, B_change, DM_type, md_start,
               md_op, ri, state
    );

    modport slave (
        output op, func, im_ready, dm_ready, md_busy,
        input  ir_we, pc_we, ALUop, Wegrf, WeDm, branch, AluSrc1, AluSrc2,
               WhichtoReg, RegDst, SignExt, B_change, DM_type, md_start,
               md_op, ri, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: decodes op/func in DECODE, holds the decoded
// control vectors until the next DECODE, and steps FETCH/DECODE/EXEC/MEM/WB/MDWAIT.
module mc_controller #(
    parameter int ALUOP_W = 7,
    parameter bit MD_EN   = 1'b1,
    parameter int WTR_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NOP    = 3'd0,
        C_BRANCH = 3'd1,
        C_WB     = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_MD     = 3'd5
    } cls_t;

    typedef struct packed {
        cls_t               cls;
        logic [ALUOP_W-1:0] aluop;
        logic [3:0]         branch;
        logic [3:0]         alu_src1;
        logic [3:0]         alu_src2;
        logic [3:0]         reg_dst;
        logic [3:0]         b_change;
        logic [3:0]         dm_type;
        logic [WTR_W-1:0]   wtr;
        logic               sign_ext;
        logic [1:0]         md_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(16);

    localparam logic [WTR_W-1:0] WTR_ALU  = WTR_W'(1);
    localparam logic [WTR_W-1:0] WTR_DM   = WTR_W'(2);
    localparam logic [WTR_W-1:0] WTR_IMM  = WTR_W'(4);
    localparam logic [WTR_W-1:0] WTR_PC4  = WTR_W'(8);
    localparam logic [WTR_W-1:0] WTR_CMP  = WTR_W'(16);
    localparam logic [WTR_W-1:0] WTR_HILO = WTR_W'(32);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, dec;
    logic       dec_ill;
    logic       dec_md_dep;
    logic [3:0] mem_type;

    // Width encoded in the low opcode bits: x0 byte, x1 half, x3 word.
    assign mem_type = bus.op[1] ? 4'b0001 : (bus.op[0] ? 4'b0010 : 4'b0100);

    always_comb begin
        dec          = '0;
        dec.cls      = C_WB;
        dec.aluop    = ALU_ADD;
        dec.branch   = 4'b0001;
        dec.alu_src1 = 4'b0001;
        dec.alu_src2 = 4'b0001;
        dec.reg_dst  = 4'b0001;
        dec.b_change = 4'b0001;
        dec.dm_type  = 4'b0001;
        dec.wtr      = WTR_ALU;
        dec_ill      = 1'b0;
        dec_md_dep   = 1'b0;
        case (bus.op)
            OP_RTYPE: begin
                case (bus.func)
                    F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                    F_AND:         dec.aluop = ALU_AND;
                    F_OR:          dec.aluop = ALU_OR;
                    F_SLT: begin
                        dec.aluop    = ALU_SUB;
                        dec.b_change = 4'b0010;
                        dec.wtr      = WTR_CMP;
                    end
                    F_SLL: begin
                        dec.aluop    = ALU_SLL;
                        dec.alu_src1 = 4'b0010;
                        dec.alu_src2 = 4'b0100;
                    end
                    F_SLLV: begin
                        dec.aluop    = ALU_SLL;
                        dec.alu_src1 = 4'b0010;
                        dec.alu_src2 = 4'b1000;
                    end
                    F_JR: begin
                        dec.cls    = C_BRANCH;
                        dec.branch = 4'b1000;
                    end
                    F_MFHI, F_MFLO: begin
                        if (MD_EN) begin
                            dec.wtr    = WTR_HILO;
                            dec_md_dep = 1'b1;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        if (MD_EN) begin
                            dec.cls    = C_MD;
                            dec.md_op  = bus.func[1:0];
                            dec_md_dep = 1'b1;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_J: begin
                dec.cls    = C_BRANCH;
                dec.branch = 4'b0100;
            end
            OP_JAL: begin
                dec.branch  = 4'b0100;
                dec.reg_dst = 4'b0100;
                dec.wtr     = WTR_PC4;
            end
            OP_BEQ, OP_BLEZ: begin
                dec.cls      = C_BRANCH;
                dec.branch   = 4'b0010;
                dec.aluop    = ALU_SUB;
                dec.sign_ext = 1'b1;
                dec.b_change = (bus.op == OP_BEQ) ? 4'b0001 : 4'b0100;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                dec.alu_src2 = 4'b0010;
                dec.reg_dst  = 4'b0010;
                dec.sign_ext = (bus.op == OP_ADDI);
                if (bus.op == OP_ANDI) dec.aluop = ALU_AND;
                if (bus.op == OP_ORI)  dec.aluop = ALU_OR;
                if (bus.op == OP_LUI)  dec.wtr   = WTR_IMM;
            end
            OP_LB, OP_LH, OP_LW: begin
                dec.cls      = C_LOAD;
                dec.alu_src2 = 4'b0010;
                dec.reg_dst  = 4'b0010;
                dec.sign_ext = 1'b1;
                dec.wtr      = WTR_DM;
                dec.dm_type  = mem_type;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.cls      = C_STORE;
                dec.alu_src2 = 4'b0010;
                dec.sign_ext = 1'b1;
                dec.dm_type  = mem_type;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) dec.cls = C_NOP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) ctrl_q <= dec;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.Wegrf    = 1'b0;
        bus.WeDm     = 1'b0;
        bus.md_start = 1'b0;
        bus.ri       = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Gated by reset so nothing is latched while the core is held.
                bus.ir_we = bus.im_ready & reset;
                if (bus.im_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ri  = dec_ill;
                state_d = (dec_md_dep && bus.md_busy) ? S_MDWAIT : S_EXEC;
            end
            S_MDWAIT: begin
                if (!bus.md_busy) state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ctrl_q.cls)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_WB:            state_d = S_WB;
                    C_MD: begin
                        bus.md_start = 1'b1;
                        bus.pc_we    = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: begin
                        bus.pc_we = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (ctrl_q.cls == C_STORE) begin
                    bus.WeDm = 1'b1;
                    if (bus.dm_ready) begin
                        bus.pc_we = 1'b1;
                        state_d   = S_FETCH;
                    end
                end else if (bus.dm_ready) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                bus.Wegrf = 1'b1;
                bus.pc_we = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.ALUop      = ctrl_q.aluop;
    assign bus.branch     = ctrl_q.branch;
    assign bus.AluSrc1    = ctrl_q.alu_src1;
    assign bus.AluSrc2    = ctrl_q.alu_src2;
    assign bus.WhichtoReg = ctrl_q.wtr;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.SignExt    = ctrl_q.sign_ext;
    assign bus.B_change   = ctrl_q.b_change;
    assign bus.DM_type    = ctrl_q.dm_type;
    assign bus.md_op      = ctrl_q.md_op;
endmodule
